// File: rtl/ascon_serial_host_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascon_serial_host_if : bit-serial link between host and Ascon wrapper |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ascon_serial_host_if;
   logic       enc_rst_o;
   logic [2:0] key_so;
   logic [2:0] nonce_so;
   logic [2:0] ad_so;
   logic [2:0] pt_so;
   logic [6:0] r64_so;
   logic       r128_so;
   logic       rpt_so;
   logic       enc_start_o;
   logic       enc_ready_i;
   logic       ct_si;
   logic       tag_si;

   modport master (
      output enc_rst_o, key_so, nonce_so, ad_so, pt_so, r64_so, r128_so, rpt_so, enc_start_o,
      input  enc_ready_i, ct_si, tag_si
   );

   modport slave (
      input  enc_rst_o, key_so, nonce_so, ad_so, pt_so, r64_so, r128_so, rpt_so, enc_start_o,
      output enc_ready_i, ct_si, tag_si
   );
endinterface
`default_nettype wire

// File: rtl/ascon_serial_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ascon_serial_host : loads 3-share inputs into the serial Ascon        |
// | wrapper MSB-first, starts it and deserialises ciphertext/tag.         |
// | Optional START timeout with err_o: define ASCON_HOST_TIMEOUT_EN.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ascon_serial_host #(
   parameter int K       = 128,
   parameter int L       = 80,
   parameter int Y       = 80,
   parameter int CAP_DLY = 1
`ifdef ASCON_HOST_TIMEOUT_EN
   ,
   parameter int TMO     = 4096
`endif
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             req_i,
   input  wire logic [3*K-1:0]   key_i,
   input  wire logic [383:0]     nonce_i,
   input  wire logic [3*L-1:0]   ad_i,
   input  wire logic [3*Y-1:0]   pt_i,
   input  wire logic [127:0]     rf128_i,
   input  wire logic [Y-1:0]     rfpt_i,
   input  wire logic [447:0]     r64_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [Y-1:0]          ct_o,
   output logic [127:0]          tag_o,
`ifdef ASCON_HOST_TIMEOUT_EN
   output logic                  err_o,
`endif
   ascon_serial_host_if.master   wr
);

   localparam int N_KN = (K > 128) ? K : 128;
   localparam int N_AP = (L > Y) ? L : Y;
   localparam int N    = (N_KN > N_AP) ? N_KN : N_AP;
   localparam int M    = (Y > 128) ? Y : 128;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRST  = 3'd1,
      S_SHIFT = 3'd2,
      S_PAD   = 3'd3,
      S_START = 3'd4,
      S_WAIT  = 3'd5,
      S_CAPT  = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;

   logic [K-1:0]   key_q   [3];
   logic [127:0]   nonce_q [3];
   logic [L-1:0]   ad_q    [3];
   logic [Y-1:0]   pt_q    [3];
   logic [63:0]    r64_q   [7];
   logic [127:0]   r128_q;
   logic [Y-1:0]   rpt_q;
   logic [Y-1:0]   ct_q;
   logic [127:0]   tag_q;

   logic       shifting;
   logic [2:0] key_s, nonce_s, ad_s, pt_s;
   logic [6:0] r64_s;

`ifdef ASCON_HOST_TIMEOUT_EN
   logic err_q, err_d;
   assign err_o = err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
`ifdef ASCON_HOST_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef ASCON_HOST_TIMEOUT_EN
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
`ifdef ASCON_HOST_TIMEOUT_EN
      err_d           = err_q;
`endif
      busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
      done_o          = (state_q == S_DONE);
      wr.enc_rst_o    = rst || (state_q == S_WRST);
      wr.enc_start_o  = (state_q == S_START);
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               state_d = S_WRST;
               cnt_d   = '0;
`ifdef ASCON_HOST_TIMEOUT_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_WRST: begin
            state_d = S_SHIFT;
            cnt_d   = '0;
         end
         S_SHIFT: begin
            if (cnt_q == 32'(N - 1)) begin
               state_d = S_PAD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_PAD: begin
            state_d = S_START;
            cnt_d   = '0;
         end
         S_START: begin
            if (wr.enc_ready_i) begin
               if (CAP_DLY <= 1) begin
                  state_d = S_CAPT;
                  cnt_d   = '0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 32'(CAP_DLY - 1);
               end
            end
`ifdef ASCON_HOST_TIMEOUT_EN
            else if (cnt_q == 32'(TMO - 1)) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
`endif
         end
         S_WAIT: begin
            if (cnt_q <= 32'd1) begin
               state_d = S_CAPT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_CAPT: begin
            if (cnt_q == 32'(M - 1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Fields shift left with zero fill, so each line goes quiet once its length is exhausted.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 3; s++) begin
            key_q[s]   <= '0;
            nonce_q[s] <= '0;
            ad_q[s]    <= '0;
            pt_q[s]    <= '0;
         end
         for (int w = 0; w < 7; w++) r64_q[w] <= '0;
         r128_q <= '0;
         rpt_q  <= '0;
         ct_q   <= '0;
         tag_q  <= '0;
      end else if ((state_q == S_IDLE) && req_i) begin
         for (int s = 0; s < 3; s++) begin
            key_q[s]   <= key_i[s*K +: K];
            nonce_q[s] <= nonce_i[s*128 +: 128];
            ad_q[s]    <= ad_i[s*L +: L];
            pt_q[s]    <= pt_i[s*Y +: Y];
         end
         for (int w = 0; w < 7; w++) r64_q[w] <= r64_i[64*w +: 64];
         r128_q <= rf128_i;
         rpt_q  <= rfpt_i;
         ct_q   <= '0;
         tag_q  <= '0;
      end else if (state_q == S_SHIFT) begin
         for (int s = 0; s < 3; s++) begin
            key_q[s]   <= {key_q[s][K-2:0], 1'b0};
            nonce_q[s] <= {nonce_q[s][126:0], 1'b0};
            ad_q[s]    <= {ad_q[s][L-2:0], 1'b0};
            pt_q[s]    <= {pt_q[s][Y-2:0], 1'b0};
         end
         for (int w = 0; w < 7; w++) r64_q[w] <= {r64_q[w][62:0], 1'b0};
         r128_q <= {r128_q[126:0], 1'b0};
         rpt_q  <= {rpt_q[Y-2:0], 1'b0};
      end else if (state_q == S_CAPT) begin
         // LSB arrives first: shift in at the top so bit j settles at index j.
         if (cnt_q < 32'(Y))   ct_q  <= {wr.ct_si, ct_q[Y-1:1]};
         if (cnt_q < 32'd128)  tag_q <= {wr.tag_si, tag_q[127:1]};
      end
   end

   assign shifting = (state_q == S_SHIFT);

   for (genvar s = 0; s < 3; s++) begin : g_share
      assign key_s[s]   = shifting & key_q[s][K-1];
      assign nonce_s[s] = shifting & nonce_q[s][127];
      assign ad_s[s]    = shifting & ad_q[s][L-1];
      assign pt_s[s]    = shifting & pt_q[s][Y-1];
   end

   for (genvar w = 0; w < 7; w++) begin : g_r64
      assign r64_s[w] = shifting & r64_q[w][63];
   end

   assign wr.key_so   = key_s;
   assign wr.nonce_so = nonce_s;
   assign wr.ad_so    = ad_s;
   assign wr.pt_so    = pt_s;
   assign wr.r64_so   = r64_s;
   assign wr.r128_so  = shifting & r128_q[127];
   assign wr.rpt_so   = shifting & rpt_q[Y-1];

   assign ct_o  = ct_q;
   assign tag_o = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_ascon_serial_host.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ascon_serial_host : self-checking bench with a stub wrapper and    |
// | a bit-level reference model. Revision: 1.0                           |
// +----------------------------------------------------------------------+
module tb_ascon_serial_host;
   localparam int K = 128;
   localparam int L = 80;
   localparam int Y = 80;
   localparam int N = 128;
   localparam int M = 128;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_i = 1'b0;
   logic [3*K-1:0]   key_i = '0;
   logic [383:0]     nonce_i = '0;
   logic [3*L-1:0]   ad_i = '0;
   logic [3*Y-1:0]   pt_i = '0;
   logic [127:0]     rf128_i = '0;
   logic [Y-1:0]     rfpt_i = '0;
   logic [447:0]     r64_i = '0;
   logic             busy_o, done_o;
   logic [Y-1:0]     ct_o;
   logic [127:0]     tag_o;
`ifdef ASCON_HOST_TIMEOUT_EN
   logic             err_o;
`endif

   logic [3*K-1:0]   key_v;
   logic [383:0]     nonce_v;
   logic [3*L-1:0]   ad_v;
   logic [3*Y-1:0]   pt_v;
   logic [127:0]     rf128_v;
   logic [Y-1:0]     rfpt_v;
   logic [447:0]     r64_v;
   logic [Y-1:0]     ct_ref;
   logic [127:0]     tag_ref;

   int checks = 0;
   int errors = 0;

   ascon_serial_host_if wr ();

   ascon_serial_host #(
      .K(K), .L(L), .Y(Y), .CAP_DLY(1)
`ifdef ASCON_HOST_TIMEOUT_EN
      , .TMO(16)
`endif
   ) dut (
      .clk(clk), .rst(rst), .req_i(req_i),
      .key_i(key_i), .nonce_i(nonce_i), .ad_i(ad_i), .pt_i(pt_i),
      .rf128_i(rf128_i), .rfpt_i(rfpt_i), .r64_i(r64_i),
      .busy_o(busy_o), .done_o(done_o), .ct_o(ct_o), .tag_o(tag_o),
`ifdef ASCON_HOST_TIMEOUT_EN
      .err_o(err_o),
`endif
      .wr(wr)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] ser_obs();
      return {wr.key_so, wr.nonce_so, wr.ad_so, wr.pt_so, wr.r64_so, wr.r128_so, wr.rpt_so};
   endfunction

   // Expected serial lines at shift count c: field bit F-1-c while c<F, else 0.
   function automatic logic [20:0] exp_ser(int c);
      logic [2:0] ek, en, ea, ep;
      logic [6:0] er;
      logic e1, e2;
      ek = '0; en = '0; ea = '0; ep = '0; er = '0; e1 = 1'b0; e2 = 1'b0;
      for (int s = 0; s < 3; s++) begin
         if (c < K)   ek[s] = key_v[s*K + K-1-c];
         if (c < 128) en[s] = nonce_v[s*128 + 127-c];
         if (c < L)   ea[s] = ad_v[s*L + L-1-c];
         if (c < Y)   ep[s] = pt_v[s*Y + Y-1-c];
      end
      for (int w = 0; w < 7; w++) if (c < 64) er[w] = r64_v[64*w + 63-c];
      if (c < 128) e1 = rf128_v[127-c];
      if (c < Y)   e2 = rfpt_v[Y-1-c];
      return {ek, en, ea, ep, er, e1, e2};
   endfunction

   task automatic rand_fields();
      for (int i = 0; i < 14; i++) begin
         key_v   = {key_v[3*K-33:0], $urandom()};
         nonce_v = {nonce_v[351:0], $urandom()};
         r64_v   = {r64_v[415:0], $urandom()};
      end
      for (int i = 0; i < 8; i++) begin
         ad_v = {ad_v[3*L-33:0], $urandom()};
         pt_v = {pt_v[3*Y-33:0], $urandom()};
      end
      for (int i = 0; i < 4; i++) begin
         rf128_v = {rf128_v[95:0], $urandom()};
         tag_ref = {tag_ref[95:0], $urandom()};
      end
      for (int i = 0; i < 3; i++) begin
         rfpt_v = {rfpt_v[Y-33:0], $urandom()};
         ct_ref = {ct_ref[Y-33:0], $urandom()};
      end
   endtask

   task automatic drive_inputs();
      key_i = key_v; nonce_i = nonce_v; ad_i = ad_v; pt_i = pt_v;
      rf128_i = rf128_v; rfpt_i = rfpt_v; r64_i = r64_v;
   endtask

   // One full transaction against the stub wrapper, checked cycle by cycle.
   task automatic txn(input int rdy_dly, input bit req_in_shift, input bit req_in_done,
                      input bit expect_tmo);
      logic [20:0] e;
      @(negedge clk);
      drive_inputs();
      req_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0;
      checks++;
      if ({busy_o, done_o, wr.enc_start_o, wr.enc_rst_o} !== 4'b1001) begin
         errors++; $display("FAIL wrst_ctl got %b exp 1001", {busy_o, done_o, wr.enc_start_o, wr.enc_rst_o});
      end
      checks++;
      if ({ct_o, tag_o, ser_obs()} !== '0) begin
         errors++; $display("FAIL wrst_clear got ct %h tag %h ser %h exp 0", ct_o, tag_o, ser_obs());
      end
`ifdef ASCON_HOST_TIMEOUT_EN
      checks++;
      if (err_o !== 1'b0) begin
         errors++; $display("FAIL err_clear got %b exp 0", err_o);
      end
`endif
      for (int c = 0; c < N; c++) begin
         @(negedge clk);
         e = exp_ser(c);
         checks++;
         if (ser_obs() !== e) begin
            errors++; $display("FAIL shift_bits cnt %0d got %h exp %h", c, ser_obs(), e);
         end
         checks++;
         if ({busy_o, done_o, wr.enc_start_o, wr.enc_rst_o} !== 4'b1000) begin
            errors++; $display("FAIL shift_ctl cnt %0d got %b exp 1000", c, {busy_o, done_o, wr.enc_start_o, wr.enc_rst_o});
         end
         req_i = req_in_shift && (c == 20);
         if (req_i) begin
            key_i = ~key_v; pt_i = ~pt_v; r64_i = ~r64_v;
         end
      end
      @(negedge clk);
      req_i = 1'b0;
      checks++;
      if ({ser_obs(), wr.enc_start_o, wr.enc_rst_o} !== 23'd0) begin
         errors++; $display("FAIL pad got ser %h start %b rst %b exp 0", ser_obs(), wr.enc_start_o, wr.enc_rst_o);
      end
      for (int w = 0; w <= (expect_tmo ? 16 : rdy_dly); w++) begin
         @(negedge clk);
         if (expect_tmo && w == 16) begin
            checks++;
            if ({busy_o, done_o, wr.enc_start_o} !== 3'b010) begin
               errors++; $display("FAIL tmo_done got %b exp 010", {busy_o, done_o, wr.enc_start_o});
            end
`ifdef ASCON_HOST_TIMEOUT_EN
            checks++;
            if ({err_o, ct_o, tag_o} !== {1'b1, {(Y+128){1'b0}}}) begin
               errors++; $display("FAIL tmo_err got err %b ct %h tag %h exp 1/0/0", err_o, ct_o, tag_o);
            end
`endif
         end else begin
            checks++;
            if ({busy_o, done_o, wr.enc_start_o} !== 3'b101) begin
               errors++; $display("FAIL start_wait %0d got %b exp 101", w, {busy_o, done_o, wr.enc_start_o});
            end
         end
         if (!expect_tmo && w == rdy_dly) wr.enc_ready_i = 1'b1;
      end
      if (expect_tmo) begin
         @(negedge clk);
         checks++;
         if ({busy_o, done_o} !== 2'b00) begin
            errors++; $display("FAIL tmo_after got %b exp 00", {busy_o, done_o});
         end
         return;
      end
      for (int j = 0; j < M; j++) begin
         @(negedge clk);
         wr.enc_ready_i = 1'b0;
         checks++;
         if ({busy_o, done_o, wr.enc_start_o} !== 3'b100) begin
            errors++; $display("FAIL capt_ctl j %0d got %b exp 100", j, {busy_o, done_o, wr.enc_start_o});
         end
         wr.ct_si  = (j < Y) ? ct_ref[j] : 1'($urandom());
         wr.tag_si = tag_ref[j];
      end
      @(negedge clk);
      wr.ct_si = 1'b0; wr.tag_si = 1'b0;
      checks++;
      if ({busy_o, done_o} !== 2'b01) begin
         errors++; $display("FAIL done_pulse got %b exp 01", {busy_o, done_o});
      end
      checks++;
      if (ct_o !== ct_ref) begin
         errors++; $display("FAIL ct got %h exp %h", ct_o, ct_ref);
      end
      checks++;
      if (tag_o !== tag_ref) begin
         errors++; $display("FAIL tag got %h exp %h", tag_o, tag_ref);
      end
      req_i = req_in_done;
      @(negedge clk);
      req_i = 1'b0;
      checks++;
      if ({busy_o, done_o, wr.enc_rst_o} !== 3'b000) begin
         errors++; $display("FAIL after_done got %b exp 000", {busy_o, done_o, wr.enc_rst_o});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_o, done_o, wr.enc_start_o, wr.enc_rst_o} !== 4'b0001) begin
         errors++; $display("FAIL reset_ctl got %b exp 0001", {busy_o, done_o, wr.enc_start_o, wr.enc_rst_o});
      end
      checks++;
      if ({ct_o, tag_o, ser_obs()} !== '0) begin
         errors++; $display("FAIL reset_data got ct %h tag %h ser %h exp 0", ct_o, tag_o, ser_obs());
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, wr.enc_rst_o} !== 3'b000) begin
         errors++; $display("FAIL post_reset got %b exp 000", {busy_o, done_o, wr.enc_rst_o});
      end
   endtask

   task automatic test_directed();
      key_v = '0; nonce_v = '0; ad_v = '0; pt_v = '0; rf128_v = '0; rfpt_v = '0; r64_v = '0;
      key_v[127:0] = 128'h000102030405060708090A0B0C0D0E0F;
      pt_v[79:0]   = 80'hA5A5A5A5A5A5A5A5A5A5;
      r64_v[63:0]  = 64'h8000_0000_0000_0001;
      ct_ref  = 80'h0123456789ABCDEF0123;
      tag_ref = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
      txn(10, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checks++;
      if ({ct_o, tag_o} !== {ct_ref, tag_ref}) begin
         errors++; $display("FAIL hold got %h %h exp %h %h", ct_o, tag_o, ct_ref, tag_ref);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3; i++) begin
         rand_fields();
         txn(int'($urandom_range(0, 5)), 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_req_ignored();
      rand_fields();
      txn(2, 1'b1, 1'b1, 1'b0);
      rand_fields();
      txn(0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_mid_reset();
      logic [20:0] e;
      bit saw_done;
      rand_fields();
      @(negedge clk);
      drive_inputs();
      req_i = 1'b1;
      @(negedge clk);
      req_i = 1'b0;
      repeat (51) @(negedge clk);
      e = exp_ser(50);
      checks++;
      if (ser_obs() !== e) begin
         errors++; $display("FAIL midrst_align got %h exp %h", ser_obs(), e);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy_o, done_o, wr.enc_start_o, wr.enc_rst_o, ser_obs()} !== {4'b0001, 21'd0}) begin
         errors++; $display("FAIL midrst_out got %b ser %h exp 0001/0", {busy_o, done_o, wr.enc_start_o, wr.enc_rst_o}, ser_obs());
      end
      rst = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_o || busy_o) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         errors++; $display("FAIL midrst_nodone got %b exp 0", saw_done);
      end
      rand_fields();
      txn(1, 1'b0, 1'b0, 1'b0);
   endtask

`ifdef ASCON_HOST_TIMEOUT_EN
   task automatic test_timeout();
      rand_fields();
      txn(0, 1'b0, 1'b0, 1'b1);
      rand_fields();
      txn(3, 1'b0, 1'b0, 1'b0);
   endtask
`endif

   initial begin
      wr.enc_ready_i = 1'b0;
      wr.ct_si       = 1'b0;
      wr.tag_si      = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_req_ignored();
      test_mid_reset();
`ifdef ASCON_HOST_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ascon_serial_host.md
Name: ascon_serial_host

Overview:
- Host-side driver for the bit-serial Ascon encryption wrapper.
- Accepts parallel 3-share key/nonce/AD/PT plus fault and mask randomness, resets the wrapper and shifts every field in MSB-first.
- Starts encryption, then deserializes the returned ciphertext and tag into parallel registers.
- Sits between a bus/testbench front end and the encryption top.

Parameters:
- K, 128, key length in bits.
- L, 80, associated-data length in bits.
- Y, 80, plaintext/ciphertext length in bits.
- CAP_DLY, 1, cycles from first sampled enc_ready_i=1 to ciphertext/tag bit 0 on the serial inputs.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  1  start request; sampled only in IDLE
- key_i  in  3K  share s at bits [sK+K-1:sK]
- nonce_i  in  384  three 128-bit shares
- ad_i  in  3L  three shares
- pt_i  in  3Y  three shares
- rf128_i  in  128  fault randomness, 128-bit
- rfpt_i  in  Y  fault randomness, plaintext-sized
- r64_i  in  448  seven 64-bit mask words; word w at [64w+63:64w]
- busy_o  out  1  high from accept until done_o
- done_o  out  1  one-cycle pulse; ct_o/tag_o valid
- ct_o  out  Y  captured ciphertext
- tag_o  out  128  captured tag
- enc_rst_o  out  1  wrapper reset
- key_so / nonce_so / ad_so / pt_so  out  3 each  serial share bits [2:0]
- r64_so  out  7  serial mask bits
- r128_so  out  1  serial rf128 bit
- rpt_so  out  1  serial rfpt bit
- enc_start_o  out  1  encryption start
- enc_ready_i  in  1  wrapper ready
- ct_si  in  1  serial ciphertext bit
- tag_si  in  1  serial tag bit

Behaviour:
- N = max(K,128,L,Y); M = max(Y,128); counters are 32-bit.
- Reset values: all outputs 0 except enc_rst_o=1 while rst=1. FSM goes to IDLE; latched inputs are cleared.
- IDLE:
  - req_i=1 latches all parallel inputs, sets busy_o, clears ct_o/tag_o, goes to WRST.
  - req_i while busy is ignored.
- WRST: one cycle with enc_rst_o=1 and serial lines 0; go to SHIFT with cnt=0.
- SHIFT: N cycles, cnt 0..N-1. Each field of length F drives its bit F-1-cnt while cnt<F, else 0:
  - key_so[s] = key share s bit K-1-cnt
  - nonce_so / r128_so: length 128
  - ad_so: L
  - pt_so / rpt_so: Y
  - r64_so[w]: bit 63-cnt while cnt<64
  - At cnt=N-1 go to PAD.
- PAD: one cycle, all serial lines 0. This makes the wrapper's counter exceed N. Go to START.
- START:
  - enc_start_o=1 and held until enc_ready_i sampled 1.
  - On that sample: drop enc_start_o, load dly=CAP_DLY-1, go to WAIT; if CAP_DLY=1, go directly to CAPT.
- WAIT: decrement dly; go to CAPT when dly=0.
- CAPT: M cycles, j=0..M-1.
  - j<Y: ct_o[j] <= ct_si.
  - j<128: tag_o[j] <= tag_si (LSB first).
  - After j=M-1 go to DONE.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle, return to IDLE. ct_o/tag_o hold until the next accept.
- If enc_ready_i falls during WAIT/CAPT, capture continues (the wrapper holds ready).
- rst mid-operation: abort immediately with reset values; no done_o.
- req_i in the DONE cycle is ignored; it is accepted in the following IDLE cycle.

Optional Feature:
- ASCON_HOST_TIMEOUT_EN defined:
  - Adds parameter TMO, default 4096, and output err_o (1 bit, reset 0).
  - In START, a counter counts cycles without enc_ready_i. At TMO: done_o pulses, err_o=1 with done_o, ct_o/tag_o stay 0, FSM returns to IDLE.
  - err_o clears on the next accept.
- Undefined: START waits indefinitely; no err_o port.

Test Plan:
- Defaults; key share0=128'h000102..0F, pt share0=80'hA5A5..A5, other shares 0; req_i one cycle -> enc_rst_o high exactly 1 cycle; key_so[0] replays 0x00,0x01.. MSB-first over 128 cycles; pt_so[0] is 0 from cnt=80 onward; enc_start_o rises at cycle 1+1+128+1 after accept.
- Stub wrapper raises enc_ready_i 10 cycles after start, then drives ct_si/tag_si LSB-first from ct=80'h0123456789ABCDEF0123 and tag=128'hDEADBEEF..., CAP_DLY=1 -> ct_o/tag_o equal those values; done_o single pulse 128 cycles after capture begins.
- r64_i word0=64'h8000_0000_0000_0001 -> r64_so[0]=1 at cnt 0 and 63, 0 elsewhere, including cnt 64..127.
- req_i pulsed during SHIFT and in the DONE cycle -> no restart; outputs unchanged; second transaction accepted only from IDLE.
- rst asserted mid-SHIFT (cnt=50) -> next cycle all outputs 0, enc_rst_o=1, no done_o; a fresh req_i completes normally.
- With ASCON_HOST_TIMEOUT_EN, TMO=16, enc_ready_i tied 0 -> done_o and err_o high 16 cycles after entering START; ct_o=0; busy_o low afterwards.
